// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant,
// binary grant index, grant-valid flag and bounded hold time (preemption).
module rr_grant_arbiter #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Saturation point of hold_cnt; with preemption disabled it is all-ones.
    localparam logic [CNT_W-1:0] HOLD_TOP   = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);
    localparam bit               PREEMPT_EN = (MAX_HOLD != 0);

    state_t           state;
    logic [IDX_W-1:0] last_ptr;
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] probe;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             owner_req;
    logic             hold_at_top;
    logic             rearb;

    assign dbg_state   = (state == GRANT);
    assign owner_req   = req[gnt_idx];
    assign hold_at_top = (hold_cnt == HOLD_TOP);

    // The current owner never competes in a rearbitration it triggered.
    always_comb begin
        cand = req;
        if (state == GRANT) begin
            cand[gnt_idx] = 1'b0;
        end
    end

    // Walk from the farthest candidate to the nearest so the first in
    // search order (last_ptr+1 upwards, wrapping) is the one left standing.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        probe     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            probe = last_ptr + IDX_W'(k);
            if (cand[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    always_comb begin
        rearb = 1'b0;
        case (state)
            IDLE:    rearb = 1'b1;
            GRANT:   rearb = !owner_req || (PREEMPT_EN && hold_at_top);
            default: rearb = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_ptr  <= IDX_W'(N_REQ - 1);
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            if (rearb && win_found) begin
                state     <= GRANT;
                last_ptr  <= win_idx;
                gnt       <= N_REQ'(1) << win_idx;
                gnt_idx   <= win_idx;
                gnt_valid <= 1'b1;
                hold_cnt  <= '0;
            end else if (state == GRANT && !owner_req) begin
                state     <= IDLE;
                gnt       <= '0;
                gnt_valid <= 1'b0;
                hold_cnt  <= '0;
            end else if (state == GRANT && !hold_at_top) begin
                hold_cnt  <= hold_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios followed by randomized
// request traffic, all checked against a cycle-level behavioural model.
module tb_rr_grant_arbiter;

    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = 5;
    localparam int W        = 1 + 3 + 8 + CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       req;
    logic [7:0]       gnt;
    logic [2:0]       gnt_idx;
    logic             gnt_valid;
    logic [CNT_W-1:0] hold_cnt;
    logic             dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    int m_owner;
    int m_last;
    int m_hold;

    // clock / reset
    always #5 clk = ~clk;

    rr_grant_arbiter #(
        .N_REQ   (8),
        .IDX_W   (3),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .hold_cnt (hold_cnt),
        .dbg_state(dbg_state)
    );

    task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // behavioural model: owner -1 means nobody holds the grant
    function automatic int search(input logic [7:0] r, input int base, input int excl);
        for (int k = 1; k <= 8; k++) begin
            int c;
            c = (base + k) % 8;
            if (c != excl && r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_hold  = 0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        int w;
        if (m_owner < 0) begin
            w = search(r, m_last, -1);
        end else if (!r[m_owner]) begin
            w = search(r, m_last, m_owner);
            if (w < 0) begin
                m_owner = -1;
                m_hold  = 0;
            end
        end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD - 1) begin
            w = search(r, m_last, m_owner);
        end else begin
            w = -1;
            m_hold = (m_hold + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_hold + 1;
        end
        if (w >= 0) begin
            m_owner = w;
            m_last  = w;
            m_hold  = 0;
        end
    endtask

    function automatic logic [W-1:0] model_outputs();
        logic       v;
        logic [2:0] i;
        logic [7:0] g;
        v = (m_owner >= 0);
        i = v ? 3'(m_owner) : 3'd0;
        g = v ? (8'h01 << m_owner) : 8'h00;
        return {v, i, g, CNT_W'(m_hold)};
    endfunction

    // scoreboard
    task automatic check_expected();
        logic [W-1:0]     e;
        logic             e_valid;
        logic [2:0]       e_idx;
        logic [7:0]       e_gnt;
        logic [CNT_W-1:0] e_hold;
        e = exp_q.pop_front();
        {e_valid, e_idx, e_gnt, e_hold} = e;
        expect_val("gnt_valid", 32'(gnt_valid), 32'(e_valid));
        expect_val("gnt", 32'(gnt), 32'(e_gnt));
        expect_val("dbg_state", 32'(dbg_state), 32'(e_valid));
        if (e_valid) begin
            expect_val("gnt_idx", 32'(gnt_idx), 32'(e_idx));
            expect_val("hold_cnt", 32'(hold_cnt), 32'(e_hold));
        end
    endtask

    // driver: called at a negedge, returns at the next negedge
    task automatic step(input logic [7:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        exp_q.push_back(model_outputs());
        #1;
        check_expected();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] r_during);
        req   = r_during;
        rst_n = 1'b0;
        #1;
        expect_val("rst_gnt", 32'(gnt), 32'h0);
        expect_val("rst_valid", 32'(gnt_valid), 32'h0);
        expect_val("rst_idx", 32'(gnt_idx), 32'h0);
        expect_val("rst_hold", 32'(hold_cnt), 32'h0);
        @(negedge clk);
        expect_val("rst_gnt_held", 32'(gnt), 32'h0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    logic [7:0] r_prev;

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        model_reset();
        @(negedge clk);
        do_reset(8'h00);

        // idle with no requests
        for (int s = 0; s < 5; s++) begin
            step(8'h00);
            expect_val("idle_idx", 32'(gnt_idx), 32'h0);
        end

        // handover without a bubble
        step(8'h24);
        expect_val("first_gnt", 32'(gnt), 32'h04);
        step(8'h20);
        expect_val("handover_gnt", 32'(gnt), 32'h20);
        step(8'h00);

        // all requesting: 16 cycles each, in index order
        do_reset(8'h00);
        for (int s = 0; s < 129; s++) begin
            step(8'hFF);
            expect_val("ff_idx", 32'(gnt_idx), 32'((s / 16) % 8));
            expect_val("ff_hold", 32'(hold_cnt), 32'(s % 16));
        end

        // lone owner saturates, then yields once a competitor appears
        do_reset(8'h00);
        for (int s = 0; s < 40; s++) begin
            step((s >= 30) ? 8'h0A : 8'h08);
            if (s < 30) begin
                expect_val("lone_gnt", 32'(gnt), 32'h08);
                expect_val("lone_hold", 32'(hold_cnt), 32'((s > 15) ? 15 : s));
            end else if (s == 30) begin
                expect_val("preempt_gnt", 32'(gnt), 32'h02);
            end
        end

        // wrap-around after owner 6
        do_reset(8'h00);
        step(8'h40);
        step(8'h00);
        step(8'h41);
        expect_val("wrap_gnt", 32'(gnt), 32'h01);

        // reset in the middle of a grant
        do_reset(8'h00);
        step(8'h10);
        expect_val("pre_rst_gnt", 32'(gnt), 32'h10);
        do_reset(8'h11);
        step(8'h11);
        expect_val("post_rst_gnt", 32'(gnt), 32'h01);

        // randomized traffic, biased towards held requests
        r_prev = 8'h00;
        for (int s = 0; s < 600; s++) begin
            logic [7:0] r;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: r = r_prev;
                6, 7:             r = 8'($urandom_range(0, 255));
                8:                r = r_prev ^ (8'h01 << $urandom_range(0, 7));
                default:          r = 8'h00;
            endcase
            if ($urandom_range(0, 199) == 0) begin
                do_reset(r);
            end
            step(r);
            r_prev = r;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Encodes the winner as a 3-bit index and presents it as a one-hot grant vector (3-to-8 decode), registered.
- Provides bounded hold time (preemption) and a registered grant-valid flag.
- Sits in front of any shared slave (bus port, memory bank, chip-select fan-out) that requesters reach through a one-hot select.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8, must equal 2**IDX_W.
- IDX_W, 3, width of the grant index.
- MAX_HOLD, 16, maximum consecutive cycles one owner holds the grant while others wait; 0 disables preemption.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector, bit i = requester i; level-sensitive.
- gnt  output  8  registered one-hot grant; all zeros when no owner.
- gnt_idx  output  3  registered binary index of current owner; valid only when gnt_valid=1.
- gnt_valid  output  1  registered; 1 while a grant is held.
- hold_cnt  output  CNT_W  cycles current owner has held the grant, from 0; CNT_W = max(1, clog2(MAX_HOLD+1)).

Behaviour:
- Reset (rst_n low, asynchronous): gnt=8'h00, gnt_idx=0, gnt_valid=0, hold_cnt=0, state=IDLE, last_ptr=7. After reset, requester 0 has the highest priority.
- Invariant: gnt == (gnt_valid ? 1<<gnt_idx : 0), checked every cycle.
- Priority search order is last_ptr+1, last_ptr+2, … last_ptr+8, all mod 8 (wrap-around). The previous owner is therefore lowest priority.
- last_ptr updates to the new gnt_idx on every edge that issues a new grant.
- FSM states: IDLE, GRANT.
- IDLE:
  - If |req, at the next edge grant the first requester in search order.
  - Go to GRANT with hold_cnt=0. Latency is 1 cycle from req sampled to gnt.
  - Otherwise stay in IDLE.
- GRANT, evaluated each edge with owner = gnt_idx:
  - Release: req[owner]=0. Rearbitrate among req with bit owner masked. If any request remains, grant the winner at this same edge (no idle bubble) with hold_cnt=0. Else gnt=0, gnt_valid=0, go to IDLE.
  - Preempt: req[owner]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and any other request present. Grant the next requester in search order, excluding owner, with hold_cnt=0.
  - Preempt condition met but no other request: keep owner and hold hold_cnt at MAX_HOLD-1 (saturate, no wrap).
  - Otherwise keep owner; hold_cnt increments, saturating at MAX_HOLD-1. When MAX_HOLD=0, hold_cnt saturates at its all-ones value.
- A new requester raising req mid-grant has no effect until release or preemption.
- A requester that drops req and re-raises it in the same cycle it is granted is treated as a release only if req was 0 at the sampled edge.
- req=8'hFF held continuously with MAX_HOLD=16: each index owns exactly 16 cycles, in order 0,1,…,7,0, …
- rst_n asserted mid-grant clears all state immediately. First grant after deassertion follows reset priority (index 0 first).
- No combinational path from req to any output.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> gnt=0, gnt_valid=0, gnt_idx=0 throughout.
- After reset, req=8'h24 (bits 2,5) -> next edge gnt=8'h04, gnt_idx=2. Drop req[2] -> next edge gnt=8'h20, gnt_idx=5, no zero cycle in between.
- req=8'hFF held, MAX_HOLD=16 -> gnt sequence 8'h01 ×16, 8'h02 ×16 … 8'h80 ×16, then 8'h01. hold_cnt runs 0..15 for each owner.
- Only req[3]=1 held for 40 cycles, MAX_HOLD=16 -> gnt=8'h08 continuously, hold_cnt saturates at 15. Raise req[1] at cycle 30 -> gnt=8'h02 at the next edge.
- Wrap-around: last owner idx 6, then req=8'h41 (bits 0,6) -> grant goes to idx 0 (8'h01), not 6.
- Assert rst_n=0 while gnt=8'h10, then release with req=8'h11 -> gnt=0 during reset. First grant after reset is 8'h01.
